// File: rtl/vga_timing_pattern_gen.sv
// vga_timing_pattern_gen
//   Programmable raster timing generator with a selectable test pattern.
//   All outputs are registered and describe the same pixel (hc,vc) in the same
//   cycle, so coordinates, syncs, blank and colour have zero relative skew.
//
// Ports
//   clk          pixel clock
//   rst_n        asynchronous active-low reset
//   en           pixel enable, one pixel advance per clk while high
//   pat[1:0]     pattern select, sampled only when the raster wraps to (0,0)
//                  0 colour bars, 1 checkerboard, 2 gradient, 3 solid
//   hc[10:0]     horizontal position 0..HTOTAL-1
//   vc[10:0]     line number 0..VTOTAL-1
//   hsync/vsync  sync outputs at HSYNCPOL/VSYNCPOL polarity
//   blank        high outside the active area (colour forced to zero)
//   r, g, b      8-bit colour components
//   frame_start  high while the presented pixel is (0,0)
//   frame_cnt    completed-frame counter, wraps modulo 2^16
module vga_timing_pattern_gen #(
  parameter int          HACTIVE  = 640,
  parameter int          HFP      = 16,
  parameter int          HSW      = 96,
  parameter int          HBP      = 48,
  parameter int          VACTIVE  = 480,
  parameter int          VFP      = 10,
  parameter int          VSW      = 2,
  parameter int          VBP      = 33,
  parameter bit          HSYNCPOL = 1'b0,
  parameter bit          VSYNCPOL = 1'b0,
  parameter logic [23:0] SOLID    = 24'h0000FF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [1:0]  pat,
  output logic [10:0] hc,
  output logic [10:0] vc,
  output logic        hsync,
  output logic        vsync,
  output logic        blank,
  output logic [7:0]  r,
  output logic [7:0]  g,
  output logic [7:0]  b,
  output logic        frame_start,
  output logic [15:0] frame_cnt
);

  localparam int HTOTAL = HACTIVE + HFP + HSW + HBP;
  localparam int VTOTAL = VACTIVE + VFP + VSW + VBP;
  localparam int BARW   = HACTIVE / 8;

  localparam logic [10:0] H_LAST   = 11'(HTOTAL - 1);
  localparam logic [10:0] V_LAST   = 11'(VTOTAL - 1);
  localparam logic [10:0] H_ACT    = 11'(HACTIVE);
  localparam logic [10:0] V_ACT    = 11'(VACTIVE);
  localparam logic [10:0] HS_START = 11'(HACTIVE + HFP);
  localparam logic [10:0] HS_END   = 11'(HACTIVE + HFP + HSW);
  localparam logic [10:0] VS_START = 11'(VACTIVE + VFP);
  localparam logic [10:0] VS_END   = 11'(VACTIVE + VFP + VSW);
  localparam logic [10:0] BAR_LAST = 11'(BARW - 1);

  // Internal state besides the output registers
  logic [1:0]  active_pat;
  logic [2:0]  bar_idx;    // colour-bar index of the presented pixel
  logic [10:0] bar_pos;    // offset of the presented pixel inside its bar
  logic        started;    // set after the first enabled edge out of reset

  // Next-pixel values
  logic [10:0] hc_next;
  logic [10:0] vc_next;
  logic        wrap_frame;
  logic [1:0]  pat_next;
  logic [15:0] frame_cnt_next;
  logic [2:0]  bar_idx_next;
  logic [10:0] bar_pos_next;
  logic        blank_next;
  logic        hsync_next;
  logic        vsync_next;
  logic [23:0] pix_next;
  logic [23:0] rgb_next;

  always_comb begin
    hc_next    = hc + 11'd1;
    vc_next    = vc;
    wrap_frame = 1'b0;
    if (hc == H_LAST) begin
      hc_next = 11'd0;
      if (vc == V_LAST) begin
        vc_next    = 11'd0;
        wrap_frame = 1'b1;
      end else begin
        vc_next = vc + 11'd1;
      end
    end
  end

  // The wrap out of reset presents (0,0) but does not complete a frame, so
  // it latches the pattern without counting.
  always_comb begin
    pat_next       = wrap_frame ? pat : active_pat;
    frame_cnt_next = (wrap_frame && started) ? frame_cnt + 16'd1 : frame_cnt;
  end

  // Bar index tracks hc with a counter instead of dividing by BARW.
  always_comb begin
    bar_idx_next = bar_idx;
    bar_pos_next = bar_pos + 11'd1;
    if (hc_next == 11'd0) begin
      bar_idx_next = 3'd0;
      bar_pos_next = 11'd0;
    end else if (bar_pos == BAR_LAST) begin
      bar_pos_next = 11'd0;
      if (bar_idx != 3'd7) bar_idx_next = bar_idx + 3'd1;
    end
  end

  always_comb begin
    blank_next = (hc_next >= H_ACT) || (vc_next >= V_ACT);
    hsync_next = ((hc_next >= HS_START) && (hc_next < HS_END)) ? HSYNCPOL : !HSYNCPOL;
    vsync_next = ((vc_next >= VS_START) && (vc_next < VS_END)) ? VSYNCPOL : !VSYNCPOL;
  end

  always_comb begin
    pix_next = 24'h000000;
    unique case (pat_next)
      2'd0: begin
        unique case (bar_idx_next)
          3'd0: pix_next = 24'hFFFFFF;
          3'd1: pix_next = 24'hFFFF00;
          3'd2: pix_next = 24'h00FFFF;
          3'd3: pix_next = 24'h00FF00;
          3'd4: pix_next = 24'hFF00FF;
          3'd5: pix_next = 24'hFF0000;
          3'd6: pix_next = 24'h0000FF;
          3'd7: pix_next = 24'h000000;
        endcase
      end
      2'd1: pix_next = (hc_next[5] ^ vc_next[5]) ? 24'hFFFFFF : 24'h000000;
      2'd2: pix_next = {hc_next[7:0], vc_next[7:0], frame_cnt_next[7:0]};
      2'd3: pix_next = SOLID;
    endcase
    rgb_next = blank_next ? 24'h000000 : pix_next;
  end

  // Reset presents the last pixel of a frame so the first enabled edge
  // lands on (0,0).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hc          <= H_LAST;
      vc          <= V_LAST;
      hsync       <= !HSYNCPOL;
      vsync       <= !VSYNCPOL;
      blank       <= 1'b1;
      r           <= 8'h00;
      g           <= 8'h00;
      b           <= 8'h00;
      frame_start <= 1'b0;
      frame_cnt   <= 16'd0;
      active_pat  <= 2'd0;
      bar_idx     <= 3'd0;
      bar_pos     <= 11'd0;
      started     <= 1'b0;
    end else if (en) begin
      hc          <= hc_next;
      vc          <= vc_next;
      hsync       <= hsync_next;
      vsync       <= vsync_next;
      blank       <= blank_next;
      r           <= rgb_next[23:16];
      g           <= rgb_next[15:8];
      b           <= rgb_next[7:0];
      frame_start <= wrap_frame;
      frame_cnt   <= frame_cnt_next;
      active_pat  <= pat_next;
      bar_idx     <= bar_idx_next;
      bar_pos     <= bar_pos_next;
      started     <= 1'b1;
    end
  end

endmodule
